dmem_responder: RTL

- Data-memory responder (slave) for the core's load/store port. Accepts one request at a time over a valid/ready request channel and returns data over a valid/ready response channel.
- Has a configurable wait-state count, so the core's load/store path can be exercised against a non-zero-latency memory.
- Sits between the CPU data-access initiator and a word-organised storage array with byte-lane write enables.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_byte_array.sv | 25 ++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Byte address to word index (drops the in-word byte offset).
    function automatic logic [63:0] wordIndex(input logic [63:0] byteAddr);
        return byteAddr >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word-organised storage with byte-lane write enables and a registered read.
// Read-before-write: rdata on a write edge returns the old word.
module mem_byte_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Per-lane write and continuous registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) mem[index][i] <= wdata[8*i +: 8];
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable wait states,
// commit (write or read) on a single edge, response held until handshake.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t                state, stateNext;
    logic [3:0]            cnt, cntNext;
    logic                  weQ;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [31:0]           wdataQ;
    logic [3:0]            beQ;
    logic                  rspErrQ;
    logic                  loadOkQ;

    logic                  accept;
    logic                  commit;
    logic                  curWe;
    logic [ADDR_WIDTH-1:0] curAddr;
    logic [31:0]           curWdata;
    logic [3:0]            curBe;
    logic                  curErr;
    logic [63:0]           curIdx;
    logic                  memWe;
    logic [31:0]           memRdata;

    assign accept = (state == IDLE) && req_valid;

    // With zero wait states the commit happens on the accept edge, so the
    // storage must see the live request rather than the latched copy.
    assign curWe    = (state == IDLE) ? req_we    : weQ;
    assign curAddr  = (state == IDLE) ? req_addr  : addrQ;
    assign curWdata = (state == IDLE) ? req_wdata : wdataQ;
    assign curBe    = (state == IDLE) ? req_be    : beQ;

    assign commit = ((state == WAIT) && (cnt == 4'd0)) ||
                    (accept && (WAIT_CYCLES == 0));

    assign curIdx = wordIndex(64'(curAddr));
    assign curErr = (curAddr[1:0] != 2'b00) || (curIdx >= 64'(DEPTH_WORDS));
    assign memWe  = commit && curWe && !curErr;

    mem_byte_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) uArray (
        .clk  (clk),
        .we   (memWe),
        .be   (curBe),
        .index(IDX_W'(curIdx)),
        .wdata(curWdata),
        .rdata(memRdata)
    );

    // State, wait counter and response flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rspErrQ <= 1'b0;
            loadOkQ <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (commit) begin
                rspErrQ <= curErr;
                loadOkQ <= !curWe && !curErr;
            end else if ((state == RESP) && rsp_ready) begin
                rspErrQ <= 1'b0;
                loadOkQ <= 1'b0;
            end
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            beQ    <= '0;
        end else if (accept) begin
            weQ    <= req_we;
            addrQ  <= req_addr;
            wdataQ <= req_wdata;
            beQ    <= req_be;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        stateNext = RESP;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) stateNext = RESP;
                else             cntNext   = cnt - 4'd1;
            end
            RESP: begin
                if (rsp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rspErrQ;
    // The array keeps re-reading the latched index, so this is stable in RESP.
    assign rsp_rdata = ((state == RESP) && loadOkQ) ? memRdata : 32'd0;

endmodule
